// File: rtl/regfile_debug_pkg.sv
// Shared constants and state encoding for the
// register-file debug arbiter.
package regfile_debug_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/drain_counter.sv
// Loadable down-counter with zero flag; counts the
// halted cycles needed to retire in-flight work.
module drain_counter
  import regfile_debug_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Shares the regfile write port and read port 1 between
// the pipeline and a debug host; halts and drains first.
module regfile_debug_arbiter
  import regfile_debug_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  input  logic              pipe_reg_write,
  input  logic [ADDR_W-1:0] pipe_write_addr,
  input  logic [DATA_W-1:0] pipe_write_data,
  input  logic [ADDR_W-1:0] pipe_rs_addr,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_rs_addr,
  input  logic [DATA_W-1:0] rf_read_data_1,
  output logic              halt
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'(DRAIN_CYCLES - 1);

  state_e state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, err_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic accept, in_access;

  drain_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (DRAIN_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign accept = dbg_req &&
    (state_q == S_IDLE || state_q == S_HOLD);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          state_d  = S_DRAIN;
          cnt_load = 1'b1;
          err_d    = 1'b0;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) state_d = S_ACCESS;
        else          cnt_dec = 1'b1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (pipe_reg_write) err_d = 1'b1;
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: begin
        // Pipeline is still drained, so skip DRAIN.
        if (dbg_req) begin
          state_d = S_ACCESS;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= dbg_we;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
      if (state_q == S_ACCESS)
        rdata_q <= rf_read_data_1;
    end
  end

  assign in_access = (state_q == S_ACCESS);

  assign rf_rs_addr    = in_access ? addr_q  : pipe_rs_addr;
  assign rf_reg_write  = in_access ? we_q    : pipe_reg_write;
  assign rf_write_addr = in_access ? addr_q  : pipe_write_addr;
  assign rf_write_data = in_access ? wdata_q : pipe_write_data;

  assign halt      = (state_q != S_IDLE);
  assign dbg_ack   = (state_q == S_RESP);
  assign dbg_err   = dbg_ack & err_q;
  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Directed bench for regfile_debug_arbiter with a
// falling-edge-write register file model.
module tb_regfile_debug_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        pipe_reg_write;
  logic [4:0]  pipe_write_addr, pipe_rs_addr;
  logic [31:0] pipe_write_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_addr, rf_rs_addr;
  logic [31:0] rf_write_data, rf_read_data_1;
  logic        halt;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_debug_arbiter #(.DRAIN_CYCLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .dbg_req         (dbg_req),
    .dbg_we          (dbg_we),
    .dbg_addr        (dbg_addr),
    .dbg_wdata       (dbg_wdata),
    .dbg_ack         (dbg_ack),
    .dbg_rdata       (dbg_rdata),
    .dbg_err         (dbg_err),
    .pipe_reg_write  (pipe_reg_write),
    .pipe_write_addr (pipe_write_addr),
    .pipe_write_data (pipe_write_data),
    .pipe_rs_addr    (pipe_rs_addr),
    .rf_reg_write    (rf_reg_write),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_rs_addr      (rf_rs_addr),
    .rf_read_data_1  (rf_read_data_1),
    .halt            (halt)
  );

  // Register file: writes on falling edge, r0 hardwired 0.
  always @(negedge clk)
    if (rf_reg_write && rf_write_addr != 5'd0)
      rf[rf_write_addr] <= rf_write_data;

  assign rf_read_data_1 =
    (rf_rs_addr == 5'd0) ? 32'd0 : rf[rf_rs_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request issued in cycle 0; checks cycles 1..6(7).
  task automatic txn(input logic we, input logic [4:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] exp_rd,
                     input logic exp_err,
                     input int inj_c, input logic [4:0] inj_a,
                     input logic [31:0] inj_d,
                     input logic chain, input logic nwe,
                     input logic [4:0] na);
    dbg_req = 1'b1;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = wd;
    for (int c = 1; c <= 6; c++) begin
      tick();
      pipe_reg_write = (c == inj_c);
      pipe_write_addr = inj_a;
      pipe_write_data = inj_d;
      #1;
      chk($sformatf("halt_c%0d", c), halt, 1'b1);
      if (c == inj_c && c != 4) begin
        chk("pass_we", rf_reg_write, 1'b1);
        chk("pass_addr", rf_write_addr, inj_a);
        chk("pass_data", rf_write_data, inj_d);
      end
      if (c == 4) begin
        chk("acc_rs", rf_rs_addr, a);
        chk("acc_we", rf_reg_write, we);
        if (we) begin
          chk("acc_waddr", rf_write_addr, a);
          chk("acc_wdata", rf_write_data, wd);
        end
      end
      if (c == 5) begin
        chk("ack", dbg_ack, 1'b1);
        chk("rdata", dbg_rdata, exp_rd);
        chk("err", dbg_err, exp_err);
      end else begin
        chk($sformatf("noack_c%0d", c), dbg_ack, 1'b0);
      end
      if (c == 6) begin
        if (chain) begin
          dbg_we = nwe;
          dbg_addr = na;
        end else begin
          dbg_req = 1'b0;
        end
      end
    end
    pipe_reg_write = 1'b0;
    if (!chain) begin
      tick();
      chk("halt_fall", halt, 1'b0);
    end
  endtask

  // Second request accepted in HOLD: ACCESS c7, ack c8.
  task automatic b2b(input logic nwe, input logic [4:0] na,
                     input logic [31:0] exp_rd);
    tick();
    chk("b2b_halt", halt, 1'b1);
    chk("b2b_noack", dbg_ack, 1'b0);
    chk("b2b_rs", rf_rs_addr, na);
    chk("b2b_we", rf_reg_write, nwe);
    tick();
    chk("b2b_ack", dbg_ack, 1'b1);
    chk("b2b_rdata", dbg_rdata, exp_rd);
    chk("b2b_err", dbg_err, 1'b0);
    tick();
    dbg_req = 1'b0;
    chk("b2b_hold", halt, 1'b1);
    tick();
    chk("b2b_fall", halt, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1'b0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = 5'd0;
    dbg_wdata = 32'd0;
    pipe_reg_write = 1'b0;
    pipe_write_addr = 5'd1;
    pipe_write_data = 32'd0;
    pipe_rs_addr = 5'd31;
    #2;
    chk("rst_halt", halt, 1'b0);
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_err", dbg_err, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_rs", rf_rs_addr, 5'd31);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset asserted in cycle 2 of a request.
    dbg_req = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 5'd5;
    tick();
    chk("rd_c1_halt", halt, 1'b1);
    tick();
    dbg_req = 1'b0;
    pipe_reg_write = 1'b1;
    pipe_write_addr = 5'd7;
    pipe_write_data = 32'h11;
    reset = 1'b0;
    #1;
    chk("rmid_halt", halt, 1'b0);
    chk("rmid_we", rf_reg_write, 1'b1);
    chk("rmid_addr", rf_write_addr, 5'd7);
    chk("rmid_data", rf_write_data, 32'h11);
    tick();
    reset = 1'b1;
    pipe_reg_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dbg_ack || halt) seen = 1'b1;
    end
    chk("rmid_noack", seen, 1'b0);

    // Preload r5 through the pipeline path.
    pipe_reg_write = 1'b1;
    pipe_write_addr = 5'd5;
    pipe_write_data = 32'h1234_5678;
    tick();
    pipe_reg_write = 1'b0;
    tick();

    txn(1'b0, 5'd5, 32'd0, 32'h1234_5678, 1'b0,
        0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);

    txn(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0,
        0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0);
    b2b(1'b0, 5'd0, 32'd0);
    tick();

    txn(1'b1, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0,
        0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd9);
    b2b(1'b0, 5'd9, 32'hDEAD_BEEF);
    tick();

    txn(1'b0, 5'd3, 32'd0, 32'h7, 1'b0,
        2, 5'd3, 32'h7, 1'b0, 1'b0, 5'd0);
    chk("r3_after", rf[3], 32'h7);
    tick();

    txn(1'b0, 5'd2, 32'd0, 32'd0, 1'b1,
        4, 5'd4, 32'h55, 1'b0, 1'b0, 5'd0);
    chk("r4_dropped", rf[4], 32'd0);
    tick();

    txn(1'b0, 5'd9, 32'd0, 32'hDEAD_BEEF, 1'b0,
        0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
